// File: rtl/mem_access_stage.sv
// Memory-access stage: ALU results pass straight through; loads and stores run a
// registered request/acknowledge transaction on the data bus while stalling upstream.
module mem_access_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        ex_valid,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_mem_addr,
    input  logic [31:0] ex_store_data,
    input  logic [31:0] ex_wdata,
    input  logic [4:0]  ex_wd,
    input  logic        ex_wreg,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] mem_wdata,
    output logic [4:0]  mem_wd,
    output logic        mem_wreg,
    output logic        mem_exc,
    output logic        stall_req
);

    localparam logic [3:0] OP_NONE = 4'd0;
    localparam logic [3:0] OP_LB   = 4'd1;
    localparam logic [3:0] OP_LBU  = 4'd2;
    localparam logic [3:0] OP_LH   = 4'd3;
    localparam logic [3:0] OP_LHU  = 4'd4;
    localparam logic [3:0] OP_LW   = 4'd5;
    localparam logic [3:0] OP_SB   = 4'd6;
    localparam logic [3:0] OP_SH   = 4'd7;
    localparam logic [3:0] OP_SW   = 4'd8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic f_is_load(input logic [3:0] op);
        return (op >= OP_LB) && (op <= OP_LW);
    endfunction

    function automatic logic f_is_store(input logic [3:0] op);
        return (op >= OP_SB) && (op <= OP_SW);
    endfunction

    function automatic logic f_misaligned(input logic [3:0] op, input logic [1:0] lane);
        logic bad;
        case (op)
            OP_LH, OP_LHU, OP_SH: bad = lane[0];
            OP_LW, OP_SW:         bad = |lane;
            default:              bad = 1'b0;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] f_store_be(input logic [3:0] op, input logic [1:0] lane);
        logic [3:0] be;
        case (op)
            OP_SB:   be = 4'b0001 << lane;
            OP_SH:   be = lane[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] f_store_wdata(input logic [3:0] op, input logic [31:0] d);
        logic [31:0] wd;
        case (op)
            OP_SB:   wd = {4{d[7:0]}};
            OP_SH:   wd = {2{d[15:0]}};
            default: wd = d;
        endcase
        return wd;
    endfunction

    // Picks the addressed lane out of the read word and extends it to 32 bits.
    function automatic logic [31:0] f_load_extract(input logic [3:0] op, input logic [1:0] lane,
                                                   input logic [31:0] rdata);
        logic signed [7:0]  byte_s;
        logic signed [15:0] half_s;
        logic signed [31:0] ext_s;
        case (lane)
            2'd0:    byte_s = rdata[7:0];
            2'd1:    byte_s = rdata[15:8];
            2'd2:    byte_s = rdata[23:16];
            default: byte_s = rdata[31:24];
        endcase
        half_s = lane[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   ext_s = byte_s;
            OP_LBU:  ext_s = {24'h0, byte_s};
            OP_LH:   ext_s = half_s;
            OP_LHU:  ext_s = {16'h0, half_s};
            default: ext_s = rdata;
        endcase
        return ext_s;
    endfunction

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_op;
    logic [1:0]  r_lane;
    logic [4:0]  r_wd;
    logic        r_wreg;
    logic [31:0] r_load_data;

    logic w_is_load;
    logic w_is_store;
    logic w_access;
    logic w_misaligned;
    logic w_start;
    logic w_ack;

    assign w_is_load    = f_is_load(ex_mem_op);
    assign w_is_store   = f_is_store(ex_mem_op);
    assign w_access     = ex_valid && (w_is_load || w_is_store);
    assign w_misaligned = f_misaligned(ex_mem_op, ex_mem_addr[1:0]);
    assign w_start      = (r_state == S_IDLE) && w_access && !w_misaligned;
    // An ack only counts while a request is actually outstanding.
    assign w_ack        = (r_state == S_BUSY) && dbus_req && dbus_ack;

    // Control state and bus registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state     <= S_IDLE;
            r_op        <= OP_NONE;
            dbus_req    <= 1'b0;
            dbus_we     <= 1'b0;
            dbus_addr   <= 32'h0;
            dbus_be     <= 4'h0;
            dbus_wdata  <= 32'h0;
            r_load_data <= 32'h0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                r_op       <= ex_mem_op;
                dbus_req   <= 1'b1;
                dbus_we    <= w_is_store;
                dbus_addr  <= {ex_mem_addr[31:2], 2'b00};
                dbus_be    <= w_is_store ? f_store_be(ex_mem_op, ex_mem_addr[1:0]) : 4'b1111;
                dbus_wdata <= w_is_store ? f_store_wdata(ex_mem_op, ex_store_data) : 32'h0;
            end else if (w_ack) begin
                dbus_req    <= 1'b0;
                r_load_data <= f_load_extract(r_op, r_lane, dbus_rdata);
            end
        end
    end

    // Write-back context held for the duration of the access.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_lane <= ex_mem_addr[1:0];
            r_wd   <= ex_wd;
            r_wreg <= ex_wreg;
        end
    end

    always_comb begin
        w_next    = r_state;
        mem_wdata = 32'h0;
        mem_wd    = 5'h0;
        mem_wreg  = 1'b0;
        mem_exc   = 1'b0;
        stall_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    stall_req = 1'b1;
                    w_next    = S_BUSY;
                end else if (w_access) begin
                    mem_exc = 1'b1;
                end else begin
                    mem_wdata = ex_wdata;
                    mem_wd    = ex_wd;
                    mem_wreg  = ex_wreg && ex_valid;
                end
            end
            S_BUSY: begin
                stall_req = 1'b1;
                if (w_ack) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                // Upstream advances on this edge, so returning to IDLE cannot retrigger.
                w_next = S_IDLE;
                if (f_is_load(r_op)) begin
                    mem_wdata = r_load_data;
                    mem_wd    = r_wd;
                    mem_wreg  = r_wreg;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (!resetn) begin
            mem_wdata = 32'h0;
            mem_wd    = 5'h0;
            mem_wreg  = 1'b0;
            mem_exc   = 1'b0;
            stall_req = 1'b0;
        end
    end

endmodule
